perf_counter_bank: RTL and testbench

Multi-channel performance-counter bank for the MP3 pipelined LC-3b core. It replaces single-trigger stall counters with NUM_CH independent channels. Each channel has a runtime-selectable counting mode, a per-channel run-length threshold, saturation with sticky overflow, and per-channel clear. A registered read port exposes any channel to the debug/MMIO logic. Triggers come from cache hit/miss, predictor, and pipeline-stall signals.

---
 rtl/lc3b_types.sv | 11 +
 rtl/perf_channel.sv | 79 +++++++
 rtl/perf_counter_bank.sv | 75 +++++++
 tb/tb_perf_counter_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions; holds the performance-counter mode encoding.
package lc3b_types;

    typedef enum logic [1:0] {
        PERF_EDGE     = 2'b00,
        PERF_LEVEL    = 2'b01,
        PERF_RUN      = 2'b10,
        PERF_RUN_CONT = 2'b11
    } perf_mode_t;

endpackage

// File: rtl/perf_channel.sv
// One performance-counter channel: mode/threshold config, run tracking,
// saturating event count with sticky overflow.
module perf_channel
    import lc3b_types::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned RUN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             trigger,
    input  logic             clr,
    input  logic             cfg_load,
    input  perf_mode_t       cfg_mode,
    input  logic [RUN_W-1:0] cfg_thresh,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    perf_mode_t       mode;
    logic [RUN_W-1:0] thresh;
    logic [RUN_W-1:0] run_len;
    logic             prev_trig;

    logic [RUN_W-1:0] thresh_eff;
    logic [RUN_W-1:0] thresh_m1;
    logic [RUN_W-1:0] run_next;
    logic             hit;

    always_comb begin
        thresh_eff = (thresh == '0) ? RUN_W'(1) : thresh;
        thresh_m1  = thresh_eff - RUN_W'(1);
        // run_len never exceeds thresh_eff, so the increment cannot wrap
        run_next   = (run_len >= thresh_eff) ? thresh_eff : run_len + RUN_W'(1);
        hit        = 1'b0;
        case (mode)
            PERF_EDGE:     hit = trigger && !prev_trig;
            PERF_LEVEL:    hit = trigger;
            PERF_RUN:      hit = trigger && (run_len == thresh_m1);
            PERF_RUN_CONT: hit = trigger && (run_len >= thresh_m1);
            default:       hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode      <= PERF_EDGE;
            thresh    <= RUN_W'(1);
            count     <= '0;
            run_len   <= '0;
            prev_trig <= 1'b0;
            ovf       <= 1'b0;
        end else if (clr || cfg_load) begin
            if (cfg_load) begin
                mode   <= cfg_mode;
                thresh <= cfg_thresh;
            end
            count     <= '0;
            run_len   <= '0;
            prev_trig <= 1'b0;
            ovf       <= 1'b0;
        end else if (!enable) begin
            run_len   <= '0;
            prev_trig <= 1'b0;
        end else begin
            prev_trig <= trigger;
            run_len   <= trigger ? run_next : '0;
            if (hit) begin
                if (&count) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH independent performance-counter channels with config
// decode and a registered read port.
module perf_counter_bank
    import lc3b_types::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned RUN_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         trigger,
    input  logic [NUM_CH-1:0]         clr,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [RUN_W-1:0]          cfg_thresh,
    input  logic [$clog2(NUM_CH)-1:0] rd_sel,
    output logic [CNT_W-1:0]          rd_data,
    output logic [NUM_CH-1:0]         ovf
);

    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] wipe;
    logic [CNT_W-1:0]  counts [NUM_CH];
    logic [CNT_W-1:0]  rd_next;

    // Out-of-range cfg_ch matches no channel, so the write is dropped
    always_comb begin
        cfg_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_we && (32'(cfg_ch) == i);
        end
    end

    assign wipe = clr | cfg_hit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        perf_channel #(
            .CNT_W (CNT_W),
            .RUN_W (RUN_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .trigger    (trigger[g]),
            .clr        (clr[g]),
            .cfg_load   (cfg_hit[g]),
            .cfg_mode   (perf_mode_t'(cfg_mode)),
            .cfg_thresh (cfg_thresh),
            .count      (counts[g]),
            .ovf        (ovf[g])
        );
    end

    // A same-cycle clear/config on the selected channel reads as zero
    always_comb begin
        rd_next = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(rd_sel) == i) begin
                rd_next = wipe[i] ? '0 : counts[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three instances (16-bit, 4-bit, 3-channel)
// share one stimulus stream and are checked against a run-length model.
module tb_perf_counter_bank;

    localparam int M_EDGE     = 0;
    localparam int M_LEVEL    = 1;
    localparam int M_RUN      = 2;
    localparam int M_RUN_CONT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] trigger;
    logic [3:0] clr;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_thresh;
    logic [1:0] rd_sel;

    logic [15:0] rd_a;
    logic [3:0]  rd_b;
    logic [7:0]  rd_c;
    logic [3:0]  ovf_a;
    logic [3:0]  ovf_b;
    logic [2:0]  ovf_c;

    int errors = 0;
    int checks = 0;

    int m_mode [4];
    int m_th   [4];
    int m_run  [4];
    int m_cnt  [3][4];
    bit m_ovf  [3][4];
    int cnt_max [3] = '{65535, 15, 255};
    int nch     [3] = '{4, 4, 3};

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(4), .CNT_W(16), .RUN_W(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .clr(clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .rd_sel(rd_sel), .rd_data(rd_a), .ovf(ovf_a)
    );

    perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .RUN_W(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .clr(clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .rd_sel(rd_sel), .rd_data(rd_b), .ovf(ovf_b)
    );

    perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .RUN_W(4)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger[2:0]), .clr(clr[2:0]),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .rd_sel(rd_sel), .rd_data(rd_c), .ovf(ovf_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model keeps the unbounded length of the current enabled high run;
    // one step applies the inputs now driven across one rising edge.
    task automatic step();
        int         rd_exp [3];
        logic [3:0] ovf_exp [3];
        bit         load;
        bit         hit;
        int         th_e;
        for (int d = 0; d < 3; d++) begin
            if (reset || int'(rd_sel) >= nch[d]) rd_exp[d] = 0;
            else if (clr[rd_sel] || (cfg_we && cfg_ch == rd_sel)) rd_exp[d] = 0;
            else rd_exp[d] = m_cnt[d][rd_sel];
        end
        for (int ch = 0; ch < 4; ch++) begin
            load = cfg_we && (int'(cfg_ch) == ch);
            if (reset || clr[ch] || load) begin
                if (reset) begin
                    m_mode[ch] = M_EDGE;
                    m_th[ch]   = 1;
                end else if (load) begin
                    m_mode[ch] = int'(cfg_mode);
                    m_th[ch]   = int'(cfg_thresh);
                end
                m_run[ch] = 0;
                for (int d = 0; d < 3; d++) begin
                    m_cnt[d][ch] = 0;
                    m_ovf[d][ch] = 1'b0;
                end
            end else if (!enable) begin
                m_run[ch] = 0;
            end else begin
                th_e = (m_th[ch] == 0) ? 1 : m_th[ch];
                case (m_mode[ch])
                    M_EDGE:  hit = trigger[ch] && (m_run[ch] == 0);
                    M_LEVEL: hit = trigger[ch];
                    M_RUN:   hit = trigger[ch] && (m_run[ch] + 1 == th_e);
                    default: hit = trigger[ch] && (m_run[ch] + 1 >= th_e);
                endcase
                for (int d = 0; d < 3; d++) begin
                    if (hit) begin
                        if (m_cnt[d][ch] == cnt_max[d]) m_ovf[d][ch] = 1'b1;
                        else m_cnt[d][ch] = m_cnt[d][ch] + 1;
                    end
                end
                m_run[ch] = trigger[ch] ? ((m_run[ch] < 1000) ? m_run[ch] + 1 : 1000) : 0;
            end
        end
        for (int d = 0; d < 3; d++) begin
            ovf_exp[d] = 4'b0;
            for (int ch = 0; ch < 4; ch++) ovf_exp[d][ch] = m_ovf[d][ch];
        end
        @(posedge clk);
        #1;
        check("rd_a", 32'(rd_a), rd_exp[0]);
        check("rd_b", 32'(rd_b), rd_exp[1]);
        check("rd_c", 32'(rd_c), rd_exp[2]);
        check("ovf_a", 32'(ovf_a), 32'(ovf_exp[0]));
        check("ovf_b", 32'(ovf_b), 32'(ovf_exp[1]));
        check("ovf_c", 32'(ovf_c), 32'(ovf_exp[2][2:0]));
    endtask

    task automatic cfg(input int ch, input int mode, input int th);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_mode   = 2'(mode);
        cfg_thresh = 4'(th);
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic pulse(input int ch, input int n);
        trigger[ch] = 1'b1;
        repeat (n) step();
        trigger[ch] = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; trigger = '0; clr = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_thresh = '0; rd_sel = '0;
        step();
        step();
        check("reset_rd_a", 32'(rd_a), 0);
        check("reset_ovf_a", 32'(ovf_a), 0);
        reset = 1'b0;

        // Default EDGE mode: one hit per 5-cycle high, two-cycle read latency
        trigger = 4'hF;
        step();
        check("edge_lat_k", 32'(rd_a), 0);
        step();
        check("edge_lat_k1", 32'(rd_a), 1);
        repeat (3) step();
        trigger = '0;
        step();
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c);
            step();
            check("edge_once", 32'(rd_a), 1);
        end
        check("edge_no_ovf", 32'(ovf_a), 0);

        cfg(1, M_RUN, 3);
        pulse(1, 2);
        pulse(1, 3);
        pulse(1, 7);
        rd_sel = 2'd1;
        step();
        check("run_thr3", 32'(rd_a), 2);

        cfg(2, M_RUN_CONT, 3);
        pulse(2, 6);
        rd_sel = 2'd2;
        step();
        check("runc_thr3", 32'(rd_a), 4);
        cfg(2, M_RUN_CONT, 0);
        pulse(2, 6);
        step();
        check("runc_thr0", 32'(rd_a), 6);

        cfg(3, M_LEVEL, 1);
        rd_sel = 2'd3;
        trigger[3] = 1'b1;
        repeat (20) step();
        check("sat_cnt_b", 32'(rd_b), 15);
        check("sat_ovf_b", 32'(ovf_b[3]), 1);
        check("nosat_cnt_a", 32'(rd_a), 19);
        clr[3] = 1'b1;
        step();
        clr[3] = 1'b0;
        trigger[3] = 1'b0;
        check("clr_rd_b", 32'(rd_b), 0);
        check("clr_ovf_b", 32'(ovf_b[3]), 0);
        step();
        check("clr_cnt_b", 32'(rd_b), 0);

        cfg(0, M_RUN, 4);
        rd_sel = 2'd0;
        trigger[0] = 1'b1;
        repeat (2) step();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        repeat (3) step();
        trigger[0] = 1'b0;
        step();
        step();
        check("run_gap", 32'(rd_a), 0);

        // Reset in the middle of activity
        rd_sel = 2'd3;
        trigger = 4'hF;
        repeat (17) step();
        check("pre_rst_ovf_b", 32'(ovf_b[3]), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        trigger = '0;
        check("rst_rd_a", 32'(rd_a), 0);
        check("rst_rd_b", 32'(rd_b), 0);
        check("rst_ovf_a", 32'(ovf_a), 0);
        check("rst_ovf_b", 32'(ovf_b), 0);

        // Channel 3 does not exist in the 3-channel instance
        cfg(3, M_LEVEL, 1);
        trigger = 4'hF;
        repeat (4) step();
        trigger = '0;
        check("oob_rd_c", 32'(rd_c), 0);
        check("oob_rd_a", 32'(rd_a), 3);
        rd_sel = 2'd0;
        step();
        check("oob_ch0_c", 32'(rd_c), 1);

        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(3) == 0) trigger[c] = ~trigger[c];
                clr[c] = ($urandom_range(31) == 0);
            end
            enable     = ($urandom_range(15) != 0);
            cfg_we     = ($urandom_range(29) == 0);
            cfg_ch     = 2'($urandom_range(3));
            cfg_mode   = 2'($urandom_range(3));
            cfg_thresh = 4'($urandom_range(6));
            rd_sel     = 2'($urandom_range(3));
            reset      = ($urandom_range(499) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
